// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and instruction memory (slave).
interface instruction_fetch_if #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDRESS_WIDTH     = 32
);
    logic                         inst_mem_rd_en;
    logic [ADDRESS_WIDTH-1:0]     inst_mem_addr;
    logic                         inst_mem_gnt;
    logic                         inst_mem_valid;
    logic [INSTRUCTION_WIDTH-1:0] inst_mem_data;

    modport master (
        output inst_mem_rd_en, inst_mem_addr,
        input  inst_mem_gnt, inst_mem_valid, inst_mem_data
    );

    modport slave (
        input  inst_mem_rd_en, inst_mem_addr,
        output inst_mem_gnt, inst_mem_valid, inst_mem_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads, buffers in-order returns and feeds decode.
// Define FETCH_PERF_CNT_EN to add the fetch/bubble performance counters.
module instruction_fetch #(
    parameter int                       INSTRUCTION_WIDTH = 32,
    parameter int                       ADDRESS_WIDTH     = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = '0,
    parameter int                       FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    instruction_fetch_if.master          mem,
    input  logic                         stall_in,
    input  logic                         branch_taken_in,
    input  logic [ADDRESS_WIDTH-1:0]     branch_target_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [ADDRESS_WIDTH-1:0]     pc_out,
    output logic                         valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  fetch_count_out,
    output logic [31:0]                  bubble_count_out
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_FLUSH} state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]     pc;
        logic [INSTRUCTION_WIDTH-1:0] instr;
    } fetch_entry_t;

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] pc, resp_pc, redirect_pc;
    fetch_entry_t             fifo_mem [FIFO_DEPTH];
    fetch_entry_t             head, resp_entry;
    logic [PW-1:0]            rd_ptr, wr_ptr;
    logic [CW-1:0]            fifo_count, outstanding, discard_cnt, discard_nxt;
    logic [CW:0]              in_flight;
    logic                     redirect, resp, drop, accept, issued;
    logic                     take, push, pop, fifo_empty;
    logic                     tgt_low_unused;

    assign redirect       = branch_taken_in;
    assign redirect_pc    = {branch_target_in[ADDRESS_WIDTH-1:2], 2'b00};
    assign tgt_low_unused = ^branch_target_in[1:0];

    assign resp       = mem.inst_mem_valid;
    assign drop       = resp && (redirect || discard_cnt != '0);
    assign accept     = resp && !drop;
    assign issued     = mem.inst_mem_rd_en && mem.inst_mem_gnt;
    assign fifo_empty = (fifo_count == '0);
    assign in_flight  = {1'b0, fifo_count} + {1'b0, outstanding};

    // Decode takes a word each unstalled cycle; an empty FIFO lets the arriving word bypass.
    assign take = !redirect && !stall_in;
    assign pop  = take && !fifo_empty;
    assign push = accept && !(take && fifo_empty);

    // Accepted responses arrive strictly in order, so their PC is a running counter.
    assign head       = fifo_mem[rd_ptr];
    assign resp_entry = '{pc: resp_pc, instr: mem.inst_mem_data};

    always_comb begin
        discard_nxt = discard_cnt;
        if (redirect)
            discard_nxt = outstanding - CW'(resp);
        else if (resp && discard_cnt != '0)
            discard_nxt = discard_cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RESET;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:           state_nxt = ST_FETCH;
            ST_FETCH, ST_FLUSH: state_nxt = (discard_nxt != '0) ? ST_FLUSH : ST_FETCH;
            default:            state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        mem.inst_mem_rd_en = 1'b0;
        if ((state == ST_FETCH || state == ST_FLUSH) && !redirect &&
            in_flight < (CW+1)'(FIFO_DEPTH))
            mem.inst_mem_rd_en = 1'b1;
    end

    assign mem.inst_mem_addr = pc;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= resp_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_PC;
            resp_pc         <= RESET_PC;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            fifo_count      <= '0;
            outstanding     <= '0;
            discard_cnt     <= '0;
            instruction_out <= '0;
            pc_out          <= '0;
            valid_out       <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(issued) - CW'(resp);
            discard_cnt <= discard_nxt;
            if (redirect) begin
                pc              <= redirect_pc;
                resp_pc         <= redirect_pc;
                rd_ptr          <= '0;
                wr_ptr          <= '0;
                fifo_count      <= '0;
                instruction_out <= '0;
                valid_out       <= 1'b0;
            end else begin
                if (issued) pc <= pc + ADDRESS_WIDTH'(4);
                if (accept) resp_pc <= resp_pc + ADDRESS_WIDTH'(4);
                if (push)   wr_ptr <= wr_ptr + PW'(1);
                if (pop)    rd_ptr <= rd_ptr + PW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (!stall_in) begin
                    if (!fifo_empty) begin
                        instruction_out <= head.instr;
                        pc_out          <= head.pc;
                        valid_out       <= 1'b1;
                    end else if (accept) begin
                        instruction_out <= resp_entry.instr;
                        pc_out          <= resp_entry.pc;
                        valid_out       <= 1'b1;
                    end else begin
                        instruction_out <= '0;
                        valid_out       <= 1'b0;
                    end
                end
            end
        end
    end

    // A response with nothing outstanding means the memory broke the protocol.
    assert property (@(posedge clk) disable iff (rst) mem.inst_mem_valid |-> outstanding != '0);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_out  <= '0;
            bubble_count_out <= '0;
        end else if (!stall_in) begin
            if (valid_out && fetch_count_out != '1)
                fetch_count_out <= fetch_count_out + 32'd1;
            if (!valid_out && bubble_count_out != '1)
                bubble_count_out <= bubble_count_out + 32'd1;
        end
    end
`endif
endmodule
